// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the async_transmitter start/busy handshake for uart_tx_arbiter.
// master drives requests and the transmitter busy flag; slave is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic [1:0]           grant_id;
    logic                 granted;
    logic                 frame_abort;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_start, tx_data, grant_id, granted, frame_abort
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_start, tx_data, grant_id, granted, frame_abort
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin frame arbiter sharing one async_transmitter among NUM_REQ byte-stream requesters.
// Whole frames are granted; a grant ends on req_last, on MAX_FRAME_LEN bytes, or on an idle timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int MAX_FRAME_LEN = 32,
    parameter int IDLE_TIMEOUT  = 4096
) (
    input logic              CLK_10MHZ,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int BCNT_W = $clog2(MAX_FRAME_LEN + 1);
    localparam int ICNT_W = $clog2(IDLE_TIMEOUT);
    localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(MAX_FRAME_LEN);
    localparam logic [ICNT_W-1:0] ICNT_END = ICNT_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT_BUSY, S_WAIT_DONE, S_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [1:0]          grant_id_q, grant_id_d;
    logic [1:0]          rr_q, rr_d;
    logic                granted_q, granted_d;
    logic                abort_q, abort_d;
    logic                last_q, last_d;
    logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [ICNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic                sel_valid, sel_last;
    logic [7:0]          sel_data;
    logic [NUM_REQ-1:0]  ready;

    function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? 2'd0 : idx + 2'd1;
    endfunction

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [1:0] ptr);
        logic [1:0] res;
        logic       found;
        res   = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++)
            for (int j = 0; j < NUM_REQ; j++)
                if (!found && v[j] && j == (int'(ptr) + k) % NUM_REQ) begin
                    res   = 2'(j);
                    found = 1'b1;
                end
        return res;
    endfunction

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        ready     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == 2'(i)) begin
                sel_valid = bus.req_valid[i];
                sel_last  = bus.req_last[i];
                sel_data  = bus.req_data[8*i +: 8];
                ready[i]  = (state_q == S_SEND) && bus.req_valid[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        rr_d       = rr_q;
        granted_d  = granted_q;
        abort_d    = 1'b0;
        last_d     = last_q;
        byte_cnt_d = byte_cnt_q;
        idle_cnt_d = idle_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (!bus.tx_busy && |bus.req_valid) begin
                    grant_id_d = rr_pick(bus.req_valid, rr_q);
                    granted_d  = 1'b1;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                if (sel_valid) begin
                    tx_data_d  = sel_data;
                    tx_start_d = 1'b1;
                    last_d     = sel_last;
                    byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                    idle_cnt_d = '0;
                    state_d    = S_WAIT_BUSY;
                end else if (idle_cnt_q == ICNT_END) begin
                    abort_d = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    idle_cnt_d = idle_cnt_q + ICNT_W'(1);
                end
            end
            // The transmitter's busy flag is registered, so it is not valid until one cycle after start.
            S_WAIT_BUSY: state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (last_q) begin
                        state_d = S_RELEASE;
                    end else if (byte_cnt_q == BCNT_MAX) begin
                        abort_d = 1'b1;
                        state_d = S_RELEASE;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end
            S_RELEASE: begin
                granted_d  = 1'b0;
                rr_d       = wrap_inc(grant_id_q);
                byte_cnt_d = '0;
                idle_cnt_d = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_10MHZ) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            grant_id_q <= 2'd0;
            rr_q       <= 2'd0;
            granted_q  <= 1'b0;
            abort_q    <= 1'b0;
            last_q     <= 1'b0;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            rr_q       <= rr_d;
            granted_q  <= granted_d;
            abort_q    <= abort_d;
            last_q     <= last_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign bus.req_ready   = ready;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.granted     = granted_q;
    assign bus.frame_abort = abort_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester and transmitter models around the DUT, with a frame-level
// round-robin reference model producing the expected transmitted byte sequence.
module tb_uart_tx_arbiter;
    localparam int N       = 3;
    localparam int MAXLEN  = 32;
    localparam int TIMEOUT = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #50 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(N), .MAX_FRAME_LEN(MAXLEN), .IDLE_TIMEOUT(TIMEOUT)
    ) dut (
        .CLK_10MHZ(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int obs_aborts = 0;
    int exp_aborts = 0;
    int proto_err = 0;
    int busy_cnt = 0;
    int busy_force = 0;
    int last_fall_cyc = 0;
    int last_abort_cyc = 0;
    int model_rr = 0;
    logic [8:0] rq [N][$];
    logic [8:0] mq [N][$];
    logic [9:0] obs_q [$];
    logic [9:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Requesters: present the queue head, pop it once the arbiter has accepted it.
    initial begin : bfm
        logic [N-1:0] acc;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge clk); #20;
            acc = bus.req_ready & bus.req_valid;
            @(posedge clk); #5;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0) begin
                    bus.req_valid[i]       = 1'b1;
                    bus.req_data[8*i +: 8] = rq[i][0][7:0];
                    bus.req_last[i]        = rq[i][0][8];
                end else begin
                    bus.req_valid[i] = 1'b0;
                    bus.req_last[i]  = 1'b0;
                end
            end
        end
    end

    // Transmitter: busy for a few cycles after each start; logs every byte and abort pulse.
    initial begin : txmodel
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk); #10;
            if (bus.frame_abort === 1'b1) begin
                obs_aborts++;
                last_abort_cyc = cyc;
            end
            if (bus.tx_start === 1'b1) begin
                if (bus.tx_busy) proto_err++;
                obs_q.push_back({bus.grant_id, bus.tx_data});
                busy_cnt = (busy_force > 0) ? busy_force : int'($urandom_range(6, 1));
                bus.tx_busy = 1'b1;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    bus.tx_busy = 1'b0;
                    last_fall_cyc = cyc;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk); #15;
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        rq[r].push_back({l, d});
        mq[r].push_back({l, d});
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += mq[i].size();
        return s;
    endfunction

    function automatic bit rq_empty();
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    // Whole frames in round-robin order among requesters holding data; a frame is cut
    // (with an abort) at MAXLEN bytes, or when its requester runs dry before its last byte.
    task automatic run_model();
        int g;
        int n;
        bit done;
        logic [8:0] b;
        while (pending() > 0) begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && mq[(model_rr + k) % N].size() > 0) g = (model_rr + k) % N;
            n = 0;
            done = 1'b0;
            while (!done) begin
                b = mq[g].pop_front();
                n++;
                exp_q.push_back({2'(g), b[7:0]});
                if (b[8]) done = 1'b1;
                else if (n == MAXLEN || mq[g].size() == 0) begin
                    done = 1'b1;
                    exp_aborts++;
                end
            end
            model_rr = (g + 1) % N;
        end
    endtask

    task automatic drain(input string tag);
        int quiet = 0;
        int t = 0;
        while (quiet < 3 && t < 20000) begin
            step();
            t++;
            if (rq_empty() && !bus.granted && !bus.tx_busy) quiet++;
            else quiet = 0;
        end
        chk({tag, " drain in time"}, 32'(t < 20000), 1);
    endtask

    task automatic compare(input string tag);
        chk({tag, " byte count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s byte%0d gid/data", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        chk({tag, " aborts"}, obs_aborts, exp_aborts);
        chk({tag, " start while busy"}, proto_err, 0);
        obs_q.delete();
        exp_q.delete();
        obs_aborts = 0;
        exp_aborts = 0;
    endtask

    initial begin : main
        int t;
        int bad;
        int nf;
        int len;
        rst = 1'b1;
        repeat (3) step();
        chk("reset tx_start", bus.tx_start, 0);
        chk("reset tx_data", bus.tx_data, 0);
        chk("reset grant_id", bus.grant_id, 0);
        chk("reset granted", bus.granted, 0);
        chk("reset frame_abort", bus.frame_abort, 0);
        chk("reset req_ready", bus.req_ready, 0);
        rst = 1'b0;
        step();

        // Single 3-byte frame with the documented latency.
        push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h0A, 1'b1);
        step(); chk("t1 ready in idle", bus.req_ready, 0);
        step(); chk("t1 ready", bus.req_ready, 3'b001);
        step(); chk("t1 tx_start", bus.tx_start, 1); chk("t1 tx_data", bus.tx_data, 8'h41);
        drain("t1"); run_model(); compare("t1");
        chk("t1 granted low", bus.granted, 0);
        chk("t1 grant_id kept", bus.grant_id, 0);

        // Two requesters valid from reset.
        rst = 1'b1;
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1); push(0, 8'h03, 1'b0); push(0, 8'h04, 1'b1);
        push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
        step();
        rst = 1'b0;
        model_rr = 0;
        drain("t2"); run_model(); compare("t2");

        // Over-long frame is cut at the length limit and the grant rotates.
        for (int i = 0; i < 40; i++) push(1, 8'(8'h80 + i), 1'(i == 39));
        push(0, 8'h61, 1'b0); push(0, 8'h62, 1'b1);
        drain("t3"); run_model(); compare("t3");

        // Requester goes quiet mid-frame.
        push(0, 8'h55, 1'b0);
        drain("t4");
        chk("t4 abort timing", last_abort_cyc - last_fall_cyc, TIMEOUT + 1);
        chk("t4 granted low", bus.granted, 0);
        run_model(); compare("t4");

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                nf = $urandom_range(2, 0);
                for (int f = 0; f < nf; f++) begin
                    len = $urandom_range(40, 1);
                    for (int b = 0; b < len; b++) push(i, 8'($urandom), 1'(b == len - 1));
                end
            end
            drain($sformatf("rand%0d", r)); run_model(); compare($sformatf("rand%0d", r));
        end

        // Reset taken while the transmitter is mid-byte.
        rst = 1'b1; step(); rst = 1'b0; step();
        rq[0].push_back({1'b1, 8'h10});
        rq[1].push_back({1'b0, 8'h20}); rq[1].push_back({1'b0, 8'h21}); rq[1].push_back({1'b1, 8'h22});
        t = 0;
        while (obs_q.size() < 1 && t < 200) begin step(); t++; end
        busy_force = 30;
        while (obs_q.size() < 2 && t < 200) begin step(); t++; end
        chk("t5 second byte started", 32'(t < 200), 1);
        busy_force = 0;
        rst = 1'b1;
        rq[0].push_back({1'b1, 8'h11});
        step();
        rst = 1'b0;
        bad = 0;
        t = 0;
        while (bus.tx_busy && t < 60) begin
            if (bus.tx_start !== 1'b0 || bus.granted !== 1'b0) bad++;
            step();
            t++;
        end
        chk("t5 quiet while busy", bad, 0);
        chk("t5 busy released", 32'(t < 60), 1);
        drain("t5");
        exp_q = '{10'h010, 10'h120, 10'h011, 10'h121, 10'h122};
        compare("t5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
